// File: rtl/instr_dispatch.sv
// Fetch/decode/dispatch controller: fetches a 16-bit word at pc, decodes the opcode and
// register fields, pulses the matching executor start, waits for its done and advances pc.
module instr_dispatch #(
  parameter int unsigned PC_W    = 8,
  parameter logic [15:0] OP_MASK = 16'h0080,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_valid,
  input  logic [15:0]     imem_data,
  output logic [15:0]     start_vec,
  output logic [5:0]      ri,
  output logic [5:0]      rj,
  input  logic [15:0]     done_vec,
  output logic            busy,
  output logic            halted,
  output logic            err_illegal,
  output logic            err_timeout,
  output logic [PC_W-1:0] pc
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_DISPATCH = 3'd3,
    S_WAIT     = 3'd4,
    S_ADVANCE  = 3'd5,
    S_HALTED   = 3'd6,
    S_ERROR    = 3'd7
  } state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_HALT   = 4'hF;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            ill_q, ill_d;
  logic            to_q, to_d;
  logic            req_q, req_d;
  logic [15:0]     start_q, start_d;
  logic [5:0]      ri_q, ri_d;
  logic [5:0]      rj_q, rj_d;
  logic            busy_q, busy_d;
  logic            halted_q, halted_d;
  logic [3:0]      op_s;

  assign op_s = ir_q[15:12];

  // Next-state, program counter, instruction register and WAIT counter
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    ill_d   = ill_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (imem_valid) begin
          ir_d    = imem_data;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        // NOP and HALT are handled here regardless of OP_MASK
        if (op_s == OP_NOP) begin
          state_d = S_ADVANCE;
        end else if (op_s == OP_HALT) begin
          state_d = S_HALTED;
        end else if (!OP_MASK[op_s]) begin
          state_d = S_ERROR;
          ill_d   = 1'b1;
        end else begin
          state_d = S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        cnt_d   = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // done is tested first so it wins over a simultaneous timeout
        if (done_vec[op_s]) begin
          state_d = S_ADVANCE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TIMEOUT_C) begin
            state_d = S_ERROR;
            to_d    = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_ADVANCE: begin
        pc_d = pc_q + PC_W'(1);
        if (run) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output values for the state being entered, so every output comes from a flop
  always_comb begin
    req_d    = 1'b0;
    start_d  = 16'h0000;
    ri_d     = 6'd0;
    rj_d     = 6'd0;
    busy_d   = 1'b0;
    halted_d = 1'b0;
    if (state_d == S_FETCH) begin
      req_d = 1'b1;
    end else begin
      req_d = 1'b0;
    end
    if (state_d == S_DISPATCH) begin
      start_d = 16'h0001 << op_s;
    end else begin
      start_d = 16'h0000;
    end
    if ((state_d == S_DISPATCH) || (state_d == S_WAIT)) begin
      ri_d = ir_q[11:6];
      rj_d = ir_q[5:0];
    end else begin
      ri_d = 6'd0;
      rj_d = 6'd0;
    end
    if ((state_d == S_IDLE) || (state_d == S_HALTED) || (state_d == S_ERROR)) begin
      busy_d = 1'b0;
    end else begin
      busy_d = 1'b1;
    end
    if (state_d == S_HALTED) begin
      halted_d = 1'b1;
    end else begin
      halted_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_q     <= 16'h0000;
      cnt_q    <= 8'd0;
      ill_q    <= 1'b0;
      to_q     <= 1'b0;
      req_q    <= 1'b0;
      start_q  <= 16'h0000;
      ri_q     <= 6'd0;
      rj_q     <= 6'd0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      cnt_q    <= cnt_d;
      ill_q    <= ill_d;
      to_q     <= to_d;
      req_q    <= req_d;
      start_q  <= start_d;
      ri_q     <= ri_d;
      rj_q     <= rj_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign imem_req    = req_q;
  assign start_vec   = start_q;
  assign ri          = ri_q;
  assign rj          = rj_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign err_illegal = ill_q;
  assign err_timeout = to_q;

endmodule

// File: tb/tb_instr_dispatch.sv
// Randomized bench for instr_dispatch: a procedural program-level model sets the expected
// outputs of every cycle, and one negedge process compares them against the DUT.
module tb_instr_dispatch;

  localparam int          PC_W    = 2;
  localparam logic [15:0] OP_MASK = 16'h00A4;
  localparam int          TIMEOUT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, run, imem_valid, imem_req;
  logic [15:0]     imem_data, done_vec, start_vec;
  logic [PC_W-1:0] imem_addr, pc;
  logic [5:0]      ri, rj;
  logic            busy, halted, err_illegal, err_timeout;

  instr_dispatch #(.PC_W(PC_W), .OP_MASK(OP_MASK), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .run(run),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_valid(imem_valid), .imem_data(imem_data),
    .start_vec(start_vec), .ri(ri), .rj(rj), .done_vec(done_vec),
    .busy(busy), .halted(halted), .err_illegal(err_illegal), .err_timeout(err_timeout), .pc(pc)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  logic            exp_req, exp_busy, exp_halt, exp_ill, exp_to;
  logic [15:0]     exp_start;
  logic [5:0]      exp_ri, exp_rj;
  logic [PC_W-1:0] exp_pc;

  int m_pc;
  bit m_halt, m_ill, m_to;

  int          n_starts;
  logic [15:0] last_start;
  logic [5:0]  last_ri, last_rj;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Per-cycle comparison against the model, plus a record of every start pulse
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("imem_req",    32'(imem_req),    32'(exp_req));
      cmp("imem_addr",   32'(imem_addr),   32'(exp_pc));
      cmp("pc",          32'(pc),          32'(exp_pc));
      cmp("start_vec",   32'(start_vec),   32'(exp_start));
      cmp("ri",          32'(ri),          32'(exp_ri));
      cmp("rj",          32'(rj),          32'(exp_rj));
      cmp("busy",        32'(busy),        32'(exp_busy));
      cmp("halted",      32'(halted),      32'(exp_halt));
      cmp("err_illegal", 32'(err_illegal), 32'(exp_ill));
      cmp("err_timeout", 32'(err_timeout), 32'(exp_to));
    end
    if (start_vec != 16'h0000) begin
      n_starts++;
      last_start = start_vec;
      last_ri    = ri;
      last_rj    = rj;
    end
  end

  task automatic rand_inputs();
    run        = 1'($urandom_range(0, 1));
    imem_valid = 1'($urandom_range(0, 1));
    imem_data  = 16'($urandom);
    done_vec   = 16'($urandom);
  endtask

  // Publish what the DUT must show in the current cycle, then move to the next cycle
  task automatic cyc(input logic e_req, input logic [15:0] e_start, input logic [5:0] e_ri,
                     input logic [5:0] e_rj, input logic e_busy);
    exp_req   = e_req;
    exp_start = e_start;
    exp_ri    = e_ri;
    exp_rj    = e_rj;
    exp_busy  = e_busy;
    exp_halt  = m_halt;
    exp_ill   = m_ill;
    exp_to    = m_to;
    exp_pc    = PC_W'(m_pc);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rand_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    m_pc   = 0;
    m_halt = 1'b0;
    m_ill  = 1'b0;
    m_to   = 1'b0;
  endtask

  task automatic park(input int n);
    for (int k = 0; k < n; k++) begin
      rand_inputs();
      if (!(m_halt || m_ill || m_to)) run = 1'b0;
      cyc(1'b0, 16'h0000, 6'd0, 6'd0, 1'b0);
    end
  endtask

  task automatic go();
    rand_inputs();
    run = 1'b1;
    cyc(1'b0, 16'h0000, 6'd0, 6'd0, 1'b0);
  endtask

  // One instruction from its first fetch cycle. done_at: WAIT cycle (1-based) where the
  // executor raises done, 0 = never. rst_at: WAIT cycle in which reset is applied, 0 = none.
  // outcome: 0 advanced, 1 halted, 2 error, 3 reset.
  task automatic exec(input logic [15:0] word, input int fwait, input int done_at,
                      input int rst_at, input bit run_after, output int outcome);
    int          op;
    int          n;
    bit          dn;
    logic [5:0]  wri, wrj;
    logic [15:0] onehot;
    op     = int'(word[15:12]);
    wri    = word[11:6];
    wrj    = word[5:0];
    onehot = 16'h0001 << op;
    for (int k = 0; k <= fwait; k++) begin
      rand_inputs();
      imem_valid = (k == fwait);
      if (k == fwait) imem_data = word;
      cyc(1'b1, 16'h0000, 6'd0, 6'd0, 1'b1);
    end
    rand_inputs();
    cyc(1'b0, 16'h0000, 6'd0, 6'd0, 1'b1);
    if (op == 15) begin
      m_halt = 1'b1; outcome = 1; return;
    end
    if (op != 0 && !OP_MASK[op]) begin
      m_ill = 1'b1; outcome = 2; return;
    end
    if (op != 0) begin
      rand_inputs();
      cyc(1'b0, onehot, wri, wrj, 1'b1);
      n = 0;
      forever begin
        rand_inputs();
        dn = (done_at > 0) && (n + 1 >= done_at);
        done_vec[op] = dn;
        if (rst_at > 0 && n + 1 == rst_at) begin
          reset = 1'b1;
          cyc(1'b0, 16'h0000, wri, wrj, 1'b1);
          reset = 1'b0;
          m_pc = 0; m_halt = 1'b0; m_ill = 1'b0; m_to = 1'b0;
          outcome = 3;
          return;
        end
        cyc(1'b0, 16'h0000, wri, wrj, 1'b1);
        if (dn) break;
        n++;
        if (n == TIMEOUT) begin
          m_to = 1'b1; outcome = 2; return;
        end
      end
    end
    rand_inputs();
    run = run_after;
    cyc(1'b0, 16'h0000, 6'd0, 6'd0, 1'b1);
    m_pc    = (m_pc + 1) % (1 << PC_W);
    outcome = 0;
  endtask

  function automatic logic [15:0] rand_word();
    int r;
    int o;
    r = $urandom_range(0, 9);
    if (r <= 4) begin
      r = $urandom_range(0, 2);
      o = (r == 0) ? 2 : ((r == 1) ? 5 : 7);
    end else if (r == 5) begin
      o = 0;
    end else if (r == 6) begin
      o = 15;
    end else if (r == 7) begin
      o = 3;
      for (int t = 0; t < 20; t++) begin
        o = $urandom_range(1, 14);
        if (!OP_MASK[o]) break;
      end
      if (OP_MASK[o]) o = 3;
    end else begin
      o = $urandom_range(0, 15);
    end
    return {4'(o), 12'($urandom)};
  endfunction

  initial begin
    int oc;
    reset = 1'b1; run = 1'b0; imem_valid = 1'b0; imem_data = 16'h0000; done_vec = 16'h0000;
    n_starts = 0; last_start = 16'h0000; last_ri = 6'd0; last_rj = 6'd0;
    do_reset();
    chk_en = 1'b1;
    park(3);
    cmp("reset_pc", 32'(pc), 32'h0);
    cmp("reset_start", 32'(start_vec), 32'h0);

    // move R1<-R2, done two cycles after start, then the next fetch at address 1
    n_starts = 0;
    go();
    exec(16'h7042, 0, 2, 0, 1'b1, oc);
    cmp("t1_fetch_addr", 32'(imem_addr), 32'h1);
    cmp("t1_fetch_req", 32'(imem_req), 32'h1);
    cmp("t1_start", 32'(last_start), 32'h0080);
    cmp("t1_ri", 32'(last_ri), 32'h1);
    cmp("t1_rj", 32'(last_rj), 32'h2);
    cmp("t1_nstarts", 32'(n_starts), 32'h1);
    exec(16'h70C5, 2, 1, 0, 1'b0, oc);
    park(2);
    cmp("t1_pc_end", 32'(pc), 32'h2);

    // NOP then HALT: no start, halted with pc=1, run toggling ignored
    do_reset(); park(1);
    n_starts = 0;
    go();
    exec(16'h0000, 0, 1, 0, 1'b1, oc);
    exec(16'hF000, 1, 1, 0, 1'b1, oc);
    park(6);
    cmp("t2_halted", 32'(halted), 32'h1);
    cmp("t2_pc", 32'(pc), 32'h1);
    cmp("t2_nstarts", 32'(n_starts), 32'h0);

    // illegal opcode after one move: pc stays at the faulting address
    do_reset(); park(1);
    n_starts = 0;
    go();
    exec(16'h7001, 0, 1, 0, 1'b1, oc);
    exec(16'h3123, 0, 1, 0, 1'b1, oc);
    park(4);
    cmp("t3_illegal", 32'(err_illegal), 32'h1);
    cmp("t3_pc", 32'(pc), 32'h1);
    cmp("t3_nstarts", 32'(n_starts), 32'h1);

    // executor never answers: timeout after TIMEOUT WAIT cycles
    do_reset(); park(1);
    go();
    exec(16'h7FFF, 0, 0, 0, 1'b1, oc);
    park(3);
    cmp("t4_timeout", 32'(err_timeout), 32'h1);
    cmp("t4_outcome", 32'(oc), 32'h2);
    cmp("t4_pc", 32'(pc), 32'h0);

    // done exactly on the last allowed WAIT cycle still advances
    do_reset(); park(1);
    go();
    exec(16'h5ABC, 0, TIMEOUT, 0, 1'b0, oc);
    park(2);
    cmp("t4b_outcome", 32'(oc), 32'h0);
    cmp("t4b_pc", 32'(pc), 32'h1);

    // four moves back to back: pc wraps 3 -> 0 and fetch resumes at 0
    do_reset(); park(1);
    go();
    for (int i = 0; i < 4; i++) exec(16'h7000 | 16'(i), 0, 1, 0, 1'b1, oc);
    cmp("t5_wrap_pc", 32'(pc), 32'h0);
    cmp("t5_wrap_addr", 32'(imem_addr), 32'h0);
    exec(16'h0000, 0, 1, 0, 1'b0, oc);
    park(2);

    // reset while waiting for done
    do_reset(); park(1);
    go();
    exec(16'h7041, 1, 0, 2, 1'b1, oc);
    park(2);
    cmp("t6_outcome", 32'(oc), 32'h3);
    cmp("t6_pc", 32'(pc), 32'h0);
    cmp("t6_ri", 32'(ri), 32'h0);
    cmp("t6_busy", 32'(busy), 32'h0);

    // randomized programs
    for (int it = 0; it < 60; it++) begin
      do_reset(); park(1); go();
      for (int j = 0; j < 6; j++) begin
        bit ra;
        ra = (j == 5) ? 1'b0 : 1'($urandom_range(0, 1));
        exec(rand_word(), $urandom_range(0, 3), $urandom_range(1, 6),
             ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0, ra, oc);
        if (oc != 0) break;
        if (!ra && j != 5) begin
          park($urandom_range(1, 2));
          go();
        end
      end
      park(2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
